// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler: registered owner index and FSM feeding a one-hot grant decoder.
// Optional hold timeout with preemption when RR_SCHED_HOLD_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner; arbitrate among requesters starting after the last owner
// GRANT | one client owns the resource until done, abandon or timeout
module rr_grant_scheduler #(
  parameter int REQUESTERS = 4,
  parameter int MAX_HOLD   = 16
) (
  input  logic                                                 clk_i,
  input  logic                                                 rst_n_i,
  input  logic [REQUESTERS-1:0]                                request_i,
  input  logic                                                 done_i,
  output logic [REQUESTERS-1:0]                                grant_o,
  output logic [$clog2((REQUESTERS > 1) ? REQUESTERS : 2)-1:0] grant_idx_o,
  output logic                                                 grant_valid_o,
  output logic                                                 preempt_o
);

  localparam int IDX_W = $clog2((REQUESTERS > 1) ? REQUESTERS : 2);

  if (REQUESTERS < 1 || MAX_HOLD < 1) begin : g_param_check
    $error("rr_grant_scheduler: REQUESTERS and MAX_HOLD must both be >= 1");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             owner_req;
  logic             release_w;
  logic             timeout_w;

  // Search only real indices; first hit above the pointer wins, else first hit at/below it.
  always_comb begin
    logic             hit_hi, hit_lo;
    logic [IDX_W-1:0] idx_hi, idx_lo;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    idx_hi = '0;
    idx_lo = '0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (request_i[i]) begin
        if (i > int'(idx_q)) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(i);
        end else begin
          hit_lo = 1'b1;
          idx_lo = IDX_W'(i);
        end
      end
    end
    win_found = hit_hi | hit_lo;
    win_idx   = hit_hi ? idx_hi : idx_lo;
  end

  assign grant_valid_o = (state_q == GRANT);
  assign grant_idx_o   = idx_q;

  for (genvar g = 0; g < REQUESTERS; g++) begin : g_dec
    assign grant_o[g] = grant_valid_o && (idx_q == IDX_W'(g));
  end

  assign owner_req = |(request_i & grant_o);
  assign release_w = grant_valid_o && (done_i || !owner_req);

`ifdef RR_SCHED_HOLD_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HOLD_W-1:0] hold_cnt_q;
  logic              preempt_q;

  // A release on the terminal cycle wins over the timeout.
  assign timeout_w = grant_valid_o && !release_w && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign preempt_o = preempt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      preempt_q <= timeout_w;
      if (state_q == IDLE) begin
        hold_cnt_q <= '0;
      end else begin
        hold_cnt_q <= hold_cnt_q + 1'b1;
      end
    end
  end
`else
  assign timeout_w = 1'b0;
  assign preempt_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
        end
      end
      GRANT: begin
        if (release_w || timeout_w) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= IDX_W'(REQUESTERS - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule
